multicycle_ctrl: RTL and testbench

//  Instruction decode and multicycle sequencer for the RV32I-subset processor.

---
 rtl/ctrl_pkg.sv | 72 +++++++
 rtl/imm_gen.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states, RV32I opcodes,
// ALU operation codes and the funct3/funct7 -> ALU operation decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] F3Word = 3'b010;
    localparam logic [2:0] F3Beq  = 3'b000;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluSrl = 4'b1000;
    localparam logic [3:0] AluSll = 4'b1001;
    localparam logic [3:0] AluSra = 4'b1010;
    localparam logic [3:0] AluXor = 4'b1101;

    typedef struct packed {
        logic       legal;
        logic [3:0] op;
    } alu_dec_t;

    // Immediate forms ignore funct7 except on shifts, where it carries the SRA select.
    function automatic alu_dec_t alu_decode(input logic [2:0] funct3, input logic [6:0] funct7,
                                            input logic is_imm);
        alu_dec_t res;
        logic     f7_base;
        res     = '{legal: 1'b0, op: AluAdd};
        f7_base = is_imm || (funct7 == F7Base);
        unique case (funct3)
            3'b000: begin
                if (f7_base) begin
                    res = '{legal: 1'b1, op: AluAdd};
                end else if (funct7 == F7Alt) begin
                    res = '{legal: 1'b1, op: AluSub};
                end
            end
            3'b001: if (funct7 == F7Base) res = '{legal: 1'b1, op: AluSll};
            3'b010: if (f7_base) res = '{legal: 1'b1, op: AluSlt};
            3'b100: if (f7_base) res = '{legal: 1'b1, op: AluXor};
            3'b101: begin
                if (funct7 == F7Base) begin
                    res = '{legal: 1'b1, op: AluSrl};
                end else if (funct7 == F7Alt) begin
                    res = '{legal: 1'b1, op: AluSra};
                end
            end
            3'b110: if (f7_base) res = '{legal: 1'b1, op: AluOr};
            3'b111: if (f7_base) res = '{legal: 1'b1, op: AluAnd};
            default: res = '{legal: 1'b0, op: AluAdd};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the I/S/B immediate form from the latched instruction's opcode.
// Shift immediates are the zero-extended shamt field; all other forms sign-extend from bit 31.
module imm_gen
    import ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic [31:0]          instr_i,
    output logic [DATAWIDTH-1:0] imm_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift;
    logic       unused_rs1;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign unused_rs1 = ^instr_i[19:15];

    always_comb begin
        imm_o = '0;
        unique case (opcode)
            OpImm: begin
                if (is_shift) begin
                    imm_o = {27'b0, instr_i[24:20]};
                end else begin
                    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OpLoad:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            OpStore:  imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OpBranch: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0};
            default:  imm_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Decode and fixed 5-state sequencer (IF, ID, EX, MEM, WB) for the RV32I-subset core.
// Only state, the latched instruction and the branch outcome are registered.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter bit          X0_GUARD  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 alu_zero,
    output logic [4:0]           read_reg1,
    output logic [4:0]           read_reg2,
    output logic [4:0]           write_reg,
    output logic                 reg_write,
    output logic [DATAWIDTH-1:0] imm,
    output logic                 alu_src,
    output logic [3:0]           alu_ctrl,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 load_pc,
    output logic                 pc_src,
    output logic                 illegal,
    output logic [2:0]           state
);

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    logic        branch_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_r, is_i, is_lw, is_sw, is_beq;
    logic        legal;
    logic        writes_rd;
    alu_dec_t    alu_dec;

    assign opcode    = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7    = instr_q[31:25];
    assign read_reg1 = instr_q[19:15];
    assign read_reg2 = instr_q[24:20];
    assign write_reg = instr_q[11:7];
    assign state     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIf;
            instr_q  <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIf) begin
                instr_q <= instr;
            end
            if (state_q == StEx) begin
                branch_q <= is_beq & alu_zero;
            end
        end
    end

    always_comb begin
        state_d = StIf;
        unique case (state_q)
            StIf:    state_d = StId;
            StId:    state_d = StEx;
            StEx:    state_d = StMem;
            StMem:   state_d = StWb;
            StWb:    state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    imm_gen #(
        .DATAWIDTH(DATAWIDTH)
    ) u_imm_gen (
        .instr_i(instr_q),
        .imm_o  (imm)
    );

    // Instruction-class decode; each class flag is only set for a fully legal encoding.
    always_comb begin
        is_r       = 1'b0;
        is_i       = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        alu_ctrl   = AluAdd;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_dec    = alu_decode(funct3, funct7, opcode == OpImm);
        unique case (opcode)
            OpR: begin
                is_r = alu_dec.legal;
                if (alu_dec.legal) alu_ctrl = alu_dec.op;
            end
            OpImm: begin
                is_i = alu_dec.legal;
                if (alu_dec.legal) begin
                    alu_ctrl = alu_dec.op;
                    alu_src  = 1'b1;
                end
            end
            OpLoad: begin
                is_lw = (funct3 == F3Word);
                alu_src    = is_lw;
                mem_to_reg = is_lw;
            end
            OpStore: begin
                is_sw   = (funct3 == F3Word);
                alu_src = is_sw;
            end
            OpBranch: begin
                is_beq = (funct3 == F3Beq);
                if (is_beq) alu_ctrl = AluSub;
            end
            default: ;
        endcase
    end

    assign legal     = is_r | is_i | is_lw | is_sw | is_beq;
    assign writes_rd = (is_r | is_i | is_lw) & ~(X0_GUARD && (write_reg == 5'd0));

    always_comb begin
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        load_pc   = 1'b0;
        pc_src    = 1'b0;
        illegal   = 1'b0;
        unique case (state_q)
            StIf: ;
            StId, StEx: illegal = ~legal;
            StMem: begin
                illegal   = ~legal;
                mem_read  = is_lw;
                mem_write = is_sw;
            end
            StWb: begin
                illegal   = ~legal;
                reg_write = writes_rd;
                load_pc   = 1'b1;
                pc_src    = branch_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction through IF..WB and checks every
// cycle's outputs against hand-decoded expectations, including an asynchronous reset in MEM.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg, load_pc, pc_src, illegal;
    logic [31:0] imm;
    logic [3:0]  alu_ctrl;
    logic [2:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_ctrl #(
        .DATAWIDTH(32),
        .X0_GUARD (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .alu_zero  (alu_zero),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .write_reg (write_reg),
        .reg_write (reg_write),
        .imm       (imm),
        .alu_src   (alu_src),
        .alu_ctrl  (alu_ctrl),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_to_reg(mem_to_reg),
        .load_pc   (load_pc),
        .pc_src    (pc_src),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Strobe vector order: {reg_write, mem_read, mem_write, load_pc}
    task automatic run_instr(input string nm, input logic [31:0] ins, input logic zero,
                             input logic [31:0] e_imm, input logic e_src, input logic [3:0] e_alu,
                             input logic [4:0] e_rd, input logic e_rw, input logic e_mr,
                             input logic e_mw, input logic e_m2r, input logic e_ill,
                             input logic e_pcs, input bit stop_in_mem);
        @(negedge clk);
        check({nm, " IF state"}, 32'(state), 32'd0);
        check({nm, " IF strobes"}, 32'({reg_write, mem_read, mem_write, load_pc}), 32'd0);
        check({nm, " IF illegal"}, 32'(illegal), 32'd0);
        instr    = ins;
        alu_zero = ~zero;

        @(negedge clk);
        check({nm, " ID state"}, 32'(state), 32'd1);
        check({nm, " ID rs1"}, 32'(read_reg1), 32'(ins[19:15]));
        check({nm, " ID rs2"}, 32'(read_reg2), 32'(ins[24:20]));
        check({nm, " ID rd"}, 32'(write_reg), 32'(e_rd));
        check({nm, " ID imm"}, imm, e_imm);
        check({nm, " ID alu_src"}, 32'(alu_src), 32'(e_src));
        check({nm, " ID alu_ctrl"}, 32'(alu_ctrl), 32'(e_alu));
        check({nm, " ID illegal"}, 32'(illegal), 32'(e_ill));
        check({nm, " ID strobes"}, 32'({reg_write, mem_read, mem_write, load_pc}), 32'd0);
        instr = 32'hFFFF_FFFF;

        @(negedge clk);
        check({nm, " EX state"}, 32'(state), 32'd2);
        check({nm, " EX alu_ctrl"}, 32'(alu_ctrl), 32'(e_alu));
        check({nm, " EX imm"}, imm, e_imm);
        check({nm, " EX strobes"}, 32'({reg_write, mem_read, mem_write, load_pc}), 32'd0);
        alu_zero = zero;

        @(negedge clk);
        alu_zero = ~zero;
        check({nm, " MEM state"}, 32'(state), 32'd3);
        check({nm, " MEM strobes"}, 32'({reg_write, mem_read, mem_write, load_pc}),
              32'({1'b0, e_mr, e_mw, 1'b0}));
        check({nm, " MEM mem_to_reg"}, 32'(mem_to_reg), 32'(e_m2r));
        check({nm, " MEM illegal"}, 32'(illegal), 32'(e_ill));
        if (!stop_in_mem) begin
            @(negedge clk);
            check({nm, " WB state"}, 32'(state), 32'd4);
            check({nm, " WB strobes"}, 32'({reg_write, mem_read, mem_write, load_pc}),
                  32'({e_rw, 1'b0, 1'b0, 1'b1}));
            check({nm, " WB pc_src"}, 32'(pc_src), 32'(e_pcs));
            check({nm, " WB mem_to_reg"}, 32'(mem_to_reg), 32'(e_m2r));
            check({nm, " WB illegal"}, 32'(illegal), 32'(e_ill));
            check({nm, " WB rd"}, 32'(write_reg), 32'(e_rd));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        instr    = 32'h0;
        alu_zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset state", 32'(state), 32'd0);
        check("reset strobes", 32'({reg_write, mem_read, mem_write, load_pc, pc_src}), 32'd0);
        check("reset instr_q rs1", 32'(read_reg1), 32'd0);
        check("reset imm", imm, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        //          name     instr         z     imm           src   alu      rd
        //          rw    mr    mw    m2r   ill   pcs   stop
        run_instr("ADD",   32'h002081B3, 1'b0, 32'h0,        1'b0, 4'b0010, 5'd3,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("ADDI0", 32'h00500013, 1'b0, 32'h5,        1'b1, 4'b0010, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("LW",    32'hFFC0A283, 1'b0, 32'hFFFFFFFC, 1'b1, 4'b0010, 5'd5,
                  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr("BEQ_T", 32'h00208463, 1'b1, 32'h8,        1'b0, 4'b0110, 5'd8,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_instr("ILL",   32'h0000007F, 1'b1, 32'h0,        1'b0, 4'b0010, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_instr("BEQ_N", 32'h00208463, 1'b0, 32'h8,        1'b0, 4'b0110, 5'd8,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("SUB",   32'h402081B3, 1'b1, 32'h0,        1'b0, 4'b0110, 5'd3,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("SRAI",  32'h4030D093, 1'b0, 32'h3,        1'b1, 4'b1010, 5'd1,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("SW",    32'h0020A423, 1'b0, 32'h8,        1'b1, 4'b0010, 5'd8,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of the SW MEM cycle
        rst_n = 1'b0;
        #1;
        check("rst mid-MEM mem_write", 32'(mem_write), 32'd0);
        check("rst mid-MEM state", 32'(state), 32'd0);
        check("rst mid-MEM rs1", 32'(read_reg1), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr("ADD2",  32'h002081B3, 1'b0, 32'h0,        1'b0, 4'b0010, 5'd3,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
